dct_fwd_4x4: RTL and testbench

DCT_FWD_4X4 -- requirements
Module: dct_fwd_4x4

---
 rtl/dct_pkg.sv | 20 ++
 rtl/dct_fwd_1d.sv | 32 +++
 rtl/dct_fwd_4x4.sv | 115 +++++++++++
 tb/tb_dct_fwd_4x4.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared widths, FSM state type and row/column array types for the 4x4 forward DCT.
package dct_pkg;

    localparam int unsigned N         = 4;
    localparam int unsigned IN_W_DEF  = 9;
    localparam int unsigned OUT_W_DEF = 16;
    localparam int unsigned BUF_W_DEF = IN_W_DEF + 3;

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_e;

    typedef logic [1:0] cnt_t;

    typedef logic signed [IN_W_DEF-1:0]  in_row_t  [N];
    typedef logic signed [BUF_W_DEF-1:0] buf_row_t [N];
    typedef logic signed [OUT_W_DEF-1:0] out_col_t [N];

endpackage

// File: rtl/dct_fwd_1d.sv
// Combinational 4-point forward integer DCT butterfly; inputs are sign-extended to the output width.
module dct_fwd_1d
    import dct_pkg::*;
#(
    parameter int unsigned IN_W_P  = IN_W_DEF,
    parameter int unsigned OUT_W_P = BUF_W_DEF
) (
    input  logic signed [IN_W_P-1:0]  i_x [N],
    output logic signed [OUT_W_P-1:0] o_y [N]
);

    logic signed [OUT_W_P-1:0] w_x [N];
    logic signed [OUT_W_P-1:0] w_a;
    logic signed [OUT_W_P-1:0] w_b;
    logic signed [OUT_W_P-1:0] w_c;
    logic signed [OUT_W_P-1:0] w_d;

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            w_x[i] = OUT_W_P'(i_x[i]);
        end
        w_a    = w_x[0] + w_x[3];
        w_b    = w_x[1] + w_x[2];
        w_c    = w_x[1] - w_x[2];
        w_d    = w_x[0] - w_x[3];
        o_y[0] = w_a + w_b;
        o_y[1] = (w_d <<< 1) + w_c;
        o_y[2] = w_a - w_b;
        o_y[3] = w_d - (w_c <<< 1);
    end

endmodule

// File: rtl/dct_fwd_4x4.sv
// 4x4 forward integer DCT: loads four rows through a row butterfly into a transpose
// buffer, then emits four column-transformed coefficient beats.
module dct_fwd_4x4
    import dct_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_row [N],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_col [N]
);

    localparam int unsigned BUF_W = IN_W + 3;

    state_e                  r_state;
    state_e                  w_state_nxt;
    cnt_t                    r_cnt;
    cnt_t                    w_cnt_nxt;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    w_load_row;
    logic signed [BUF_W-1:0] r_buf      [N][N];
    logic signed [BUF_W-1:0] w_buf_nxt  [N][N];
    logic signed [BUF_W-1:0] w_row_coef [N];
    logic signed [OUT_W-1:0] w_col_in   [N];
    logic signed [OUT_W-1:0] w_col_coef [N];
    logic signed [OUT_W-1:0] r_out_col  [N];

    dct_fwd_1d #(
        .IN_W_P (IN_W),
        .OUT_W_P(BUF_W)
    ) u_row_pass (
        .i_x(in_row),
        .o_y(w_row_coef)
    );

    dct_fwd_1d #(
        .IN_W_P (OUT_W),
        .OUT_W_P(OUT_W)
    ) u_col_pass (
        .i_x(w_col_in),
        .o_y(w_col_coef)
    );

    // Next-state and counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load_row  = 1'b0;
        unique case (r_state)
            LOAD: begin
                if (in_valid && r_in_ready) begin
                    w_load_row = 1'b1;
                    w_cnt_nxt  = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_state_nxt = EMIT;
                    end
                end
            end
            EMIT: begin
                if (out_valid && out_ready) begin
                    w_cnt_nxt = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_state_nxt = LOAD;
                    end
                end
            end
            default: begin
                w_state_nxt = LOAD;
            end
        endcase
    end

    // Column pass looks ahead at the post-edge buffer so out_col can be registered
    always_comb begin
        w_buf_nxt = r_buf;
        if (w_load_row) begin
            w_buf_nxt[r_cnt] = w_row_coef;
        end
        for (int i = 0; i < int'(N); i++) begin
            w_col_in[i] = OUT_W'(w_buf_nxt[i][w_cnt_nxt]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= LOAD;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_in_ready  <= (w_state_nxt == LOAD);
            r_out_valid <= (w_state_nxt == EMIT);
        end
    end

    // Datapath registers need no reset: a partial block is discarded via cnt/state
    always_ff @(posedge clk) begin
        r_buf     <= w_buf_nxt;
        r_out_col <= w_col_coef;
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_col   = r_out_col;

endmodule

// File: tb/tb_dct_fwd_4x4.sv
// Self-checking bench for dct_fwd_4x4 against a matrix-product reference Y = C*X*C^T.
module tb_dct_fwd_4x4;
    import dct_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n;
    logic     in_valid;
    logic     in_ready;
    in_row_t  in_row;
    logic     out_valid;
    logic     out_ready;
    out_col_t out_col;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int cm [4][4] = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};

    dct_fwd_4x4 #(
        .IN_W (IN_W_DEF),
        .OUT_W(OUT_W_DEF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_row   (in_row),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_col  (out_col)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void golden(input int x[4][4], output int y[4][4]);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                int s = 0;
                for (int k = 0; k < 4; k++) begin
                    for (int l = 0; l < 4; l++) begin
                        s += cm[i][k] * x[k][l] * cm[j][l];
                    end
                end
                y[i][j] = s;
            end
        end
    endfunction

    function automatic int rnd_sample();
        return int'($urandom_range(510, 0)) - 255;
    endfunction

    task automatic garbage_row();
        for (int l = 0; l < 4; l++) in_row[l] = IN_W_DEF'(rnd_sample());
    endtask

    // Drives the first nrows rows of x; optional idle gaps with junk on in_row
    task automatic drive_rows(input int x[4][4], input int nrows, input bit gaps);
        for (int r = 0; r < nrows; r++) begin
            int g = 0;
            if (gaps) begin
                in_valid = 1'b0;
                garbage_row();
                repeat ($urandom_range(2, 0)) @(negedge clk);
            end
            in_valid = 1'b1;
            for (int l = 0; l < 4; l++) in_row[l] = IN_W_DEF'(x[r][l]);
            while (!in_ready && g < 16) begin
                @(negedge clk);
                g++;
            end
            if (g >= 16) check("in_ready_timeout", longint'(in_ready), 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic recv_block(input int y[4][4], input bit garbage, input int stall_beat,
                              output int first_cyc);
        first_cyc = 0;
        out_ready = 1'b1;
        check("latency_valid", longint'(out_valid), 1);
        for (int j = 0; j < 4; j++) begin
            int g = 0;
            while (!out_valid && g < 16) begin
                @(negedge clk);
                g++;
            end
            if (g >= 16) check("out_valid_timeout", longint'(out_valid), 1);
            if (j == 0) first_cyc = cyc;
            if (j == stall_beat) begin
                out_ready = 1'b0;
                repeat (5) begin
                    for (int i = 0; i < 4; i++) check("stall_col", longint'(out_col[i]), y[i][j]);
                    check("stall_in_ready", longint'(in_ready), 0);
                    check("stall_valid", longint'(out_valid), 1);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            for (int i = 0; i < 4; i++) check("beat", longint'(out_col[i]), y[i][j]);
            check("emit_in_ready", longint'(in_ready), 0);
            if (garbage) begin
                in_valid = 1'b1;
                garbage_row();
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_block(input int x[4][4], input bit gaps, input bit garbage,
                             input int stall_beat, output int first_cyc);
        int y[4][4];
        golden(x, y);
        drive_rows(x, 4, gaps);
        recv_block(y, garbage, stall_beat, first_cyc);
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int x[4][4];
        int fc;
        int prev_fc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int l = 0; l < 4; l++) in_row[l] = '0;
        @(negedge clk);
        apply_reset();
        @(negedge clk);
        check("idle_in_ready", longint'(in_ready), 1);
        check("idle_out_valid", longint'(out_valid), 0);

        // Impulse at X[0][0]
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) x[r][c] = 0;
        x[0][0] = 1;
        run_block(x, 1'b0, 1'b0, -1, fc);

        // Flat +255 and flat -255
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) x[r][c] = 255;
        run_block(x, 1'b0, 1'b0, -1, fc);
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) x[r][c] = -255;
        run_block(x, 1'b0, 1'b0, -1, fc);

        // Random back-to-back blocks; garbage rows offered during EMIT on odd blocks
        prev_fc = 0;
        for (int b = 0; b < 8; b++) begin
            for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) x[r][c] = rnd_sample();
            run_block(x, 1'b0, 1'(b % 2), -1, fc);
            if (b > 0) check("block_period", fc - prev_fc, 8);
            prev_fc = fc;
        end

        // Backpressure on beat 1
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) x[r][c] = rnd_sample();
        run_block(x, 1'b0, 1'b0, 1, fc);

        // Idle gaps between rows with junk on in_row
        for (int b = 0; b < 3; b++) begin
            for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) x[r][c] = rnd_sample();
            run_block(x, 1'b1, 1'b1, -1, fc);
        end

        // Reset after two rows: the next four rows form a fresh block
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) x[r][c] = rnd_sample();
        drive_rows(x, 2, 1'b0);
        apply_reset();
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) x[r][c] = rnd_sample();
        run_block(x, 1'b0, 1'b0, -1, fc);

        // Reset during EMIT drops the pending beats
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) x[r][c] = rnd_sample();
        drive_rows(x, 4, 1'b0);
        check("pre_reset_valid", longint'(out_valid), 1);
        apply_reset();
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) x[r][c] = rnd_sample();
        run_block(x, 1'b0, 1'b1, 2, fc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
